// File: rtl/cpu_defs_pkg.sv
// Shared EX-stage definitions: multiply/divide op encodings, FSM states, default width.
package cpu_defs_pkg;

    localparam int unsigned MD_WIDTH = 16;

    // op[1] selects divide, op[0] selects signed
    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StFixup = 2'b10,
        StDone  = 2'b11
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// MUL: {acc, shreg} is the partial product with the multiplier in shreg, operand = multiplicand.
// DIV: acc is the partial remainder, shreg holds dividend bits shifting out and quotient
// bits shifting in, operand = divisor.
module muldiv_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_mode_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shreg
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_shift;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    // Compute both candidate updates and select by mode
    always_comb begin
        w_sum       = {1'b0, i_acc} + (i_shreg[0] ? {1'b0, i_operand} : '0);
        w_rem_shift = {i_acc, i_shreg[WIDTH-1]};
        w_diff      = w_rem_shift - {1'b0, i_operand};
        w_fits      = (w_rem_shift >= {1'b0, i_operand});
        o_acc       = '0;
        o_shreg     = '0;
        if (i_mode_div) begin
            // Divisor of zero always "fits": quotient fills with ones, remainder = dividend
            if (w_fits) begin
                o_acc   = w_diff[WIDTH-1:0];
                o_shreg = {i_shreg[WIDTH-2:0], 1'b1};
            end else begin
                o_acc   = w_rem_shift[WIDTH-1:0];
                o_shreg = {i_shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc   = w_sum[WIDTH:1];
            o_shreg = {w_sum[0], i_shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU. Works on operand magnitudes
// for WIDTH cycles, then applies sign correction once in FIXUP.
module ex_muldiv_unit
    import cpu_defs_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [WIDTH-1:0] ALU_Remainder,
    output logic             done,
    output logic             busy,
    output logic             stall,
    output logic             div_zero
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e          r_state;
    logic [CntW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_operand;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_done;
    logic               r_busy;
    logic               r_div_zero;

    logic               w_is_div;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Decode the incoming op and take operand magnitudes (unsigned ops keep raw values)
    always_comb begin
        w_is_div = (op == OP_DIVU) || (op == OP_DIV);
        w_sign_a = ((op == OP_MUL) || (op == OP_DIV)) && opA[WIDTH-1];
        w_sign_b = ((op == OP_MUL) || (op == OP_DIV)) && opB[WIDTH-1];
        w_mag_a  = w_sign_a ? (~opA + 1'b1) : opA;
        w_mag_b  = w_sign_b ? (~opB + 1'b1) : opB;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_mode_div (r_is_div),
        .i_acc      (r_acc),
        .i_shreg    (r_shreg),
        .i_operand  (r_operand),
        .o_acc      (w_acc_nxt),
        .o_shreg    (w_shreg_nxt)
    );

    // Sign correction of the finished magnitude result
    always_comb begin
        w_prod     = {r_acc, r_shreg};
        w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
        w_quot_fix = r_dz ? '1 : (r_neg_q ? (~r_shreg + 1'b1) : r_shreg);
        w_rem_fix  = r_neg_r ? (~r_acc + 1'b1) : r_acc;
    end

    // FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_shreg     <= '0;
            r_operand   <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_div_zero  <= 1'b0;
        end else if (flush) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= StRun;
                        r_busy    <= 1'b1;
                        r_cnt     <= CntW'(WIDTH - 1);
                        r_acc     <= '0;
                        r_is_div  <= w_is_div;
                        r_shreg   <= w_is_div ? w_mag_a : w_mag_b;
                        r_operand <= w_is_div ? w_mag_b : w_mag_a;
                        r_neg_q   <= w_sign_a ^ w_sign_b;
                        r_neg_r   <= w_sign_a & w_is_div;
                        r_dz      <= w_is_div && (opB == '0);
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                StRun: begin
                    r_acc   <= w_acc_nxt;
                    r_shreg <= w_shreg_nxt;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= StFixup;
                    end
                end
                StFixup: begin
                    if (r_is_div) begin
                        r_result    <= w_quot_fix;
                        r_remainder <= w_rem_fix;
                    end else begin
                        r_result    <= w_prod_fix[WIDTH-1:0];
                        r_remainder <= w_prod_fix[2*WIDTH-1:WIDTH];
                    end
                    r_div_zero <= r_dz;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= StDone;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ALU_Result    = r_result;
    assign ALU_Remainder = r_remainder;
    assign done          = r_done;
    assign busy          = r_busy;
    assign div_zero      = r_div_zero;
    assign stall         = (start && ((r_state == StIdle) || (r_state == StDone))) || r_busy;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed results, latency and control behaviour.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [15:0] ALU_Result;
    logic [15:0] ALU_Remainder;
    logic        done;
    logic        busy;
    logic        stall;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    ex_muldiv_unit #(
        .WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .flush         (flush),
        .op            (op),
        .opA           (opA),
        .opB           (opB),
        .ALU_Result    (ALU_Result),
        .ALU_Remainder (ALU_Remainder),
        .done          (done),
        .busy          (busy),
        .stall         (stall),
        .div_zero      (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue start in the current cycle (cycle 0), scramble inputs during RUN, and stop in
    // cycle 18 where done must be high. Leaves the DUT in DONE.
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [15:0] erem, input logic edz,
                          input string tag);
        op    = o;
        opA   = a;
        opB   = b;
        start = 1'b1;
        #1;
        check({tag, "_stall_c0"}, 16'(stall), 16'h1);
        tick();
        start = 1'b0;
        opA   = ~a;
        opB   = ~b;
        op    = ~o;
        for (int c = 1; c < 18; c++) begin
            check({tag, "_stall_run"}, 16'(stall), 16'h1);
            check({tag, "_no_early_done"}, 16'(done), 16'h0);
            tick();
        end
        check({tag, "_done_c18"}, 16'(done), 16'h1);
        check({tag, "_result"}, ALU_Result, er);
        check({tag, "_remainder"}, ALU_Remainder, erem);
        check({tag, "_div_zero"}, 16'(div_zero), 16'(edz));
        check({tag, "_busy_done"}, 16'(busy), 16'h0);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        opA   = '0;
        opB   = '0;
        tick();
        tick();
        check("rst_result", ALU_Result, 16'h0);
        check("rst_remainder", ALU_Remainder, 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_div_zero", 16'(div_zero), 16'h0);
        check("rst_stall", 16'(stall), 16'h0);
        rst_n = 1'b1;
        tick();

        // 1. MULU 0x00FF * 0x0101 = 0x0000FFFF
        run_op(2'b00, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, "mulu");
        tick();
        check("mulu_done_one_cycle", 16'(done), 16'h0);
        check("mulu_hold_result", ALU_Result, 16'hFFFF);
        check("idle_stall_low", 16'(stall), 16'h0);

        // 2. MUL -2 * 3 = -6
        run_op(2'b01, 16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 1'b0, "mul");
        tick();

        // 3. DIV -7 / 2 = -3 rem -1 ; 0x8000 / -1 wraps
        run_op(2'b11, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, "div_neg");
        tick();
        run_op(2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, "div_wrap");
        tick();

        // 4. DIVU by zero
        run_op(2'b10, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 1'b1, "divu_zero");
        tick();

        // 5. flush during cycle 5 of a DIVU
        op    = 2'b10;
        opA   = 16'h1234;
        opB   = 16'h0005;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 16'(busy), 16'h0);
        check("flush_stall", 16'(stall), 16'h0);
        check("flush_done", 16'(done), 16'h0);
        check("flush_keep_result", ALU_Result, 16'hFFFF);
        check("flush_keep_remainder", ALU_Remainder, 16'h0064);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("flush_no_done", 16'(seen), 16'h0);
        run_op(2'b10, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, "divu_after_flush");
        tick();

        // 6a. reset mid-RUN
        op    = 2'b00;
        opA   = 16'h0012;
        opB   = 16'h0034;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        check("pre_rst_busy", 16'(busy), 16'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_result", ALU_Result, 16'h0);
        check("midrst_remainder", ALU_Remainder, 16'h0);
        check("midrst_busy", 16'(busy), 16'h0);
        check("midrst_done", 16'(done), 16'h0);
        check("midrst_div_zero", 16'(div_zero), 16'h0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        check("midrst_stays_idle", 16'(seen), 16'h0);

        // 6b. start while busy is ignored, then back-to-back start from DONE
        op    = 2'b10;
        opA   = 16'h0064;
        opB   = 16'h0007;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        op    = 2'b00;
        opA   = 16'h0002;
        opB   = 16'h0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 4; c < 18; c++) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("busy_start_no_early", 16'(seen), 16'h0);
        check("busy_start_done", 16'(done), 16'h1);
        check("busy_start_result", ALU_Result, 16'h000E);
        check("busy_start_remainder", ALU_Remainder, 16'h0002);
        run_op(2'b01, 16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 1'b0, "b2b");
        tick();
        check("b2b_done_cleared", 16'(done), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
